// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU constants, loader state encoding and operand vector type.
package npu_pkg;

    localparam int DEF_VEC_LEN = 32;

    typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} ld_state_t;

    typedef logic [DEF_VEC_LEN-1:0][7:0] int8_vec_t;

endpackage

// File: rtl/dot_operand_loader_if.sv
// dot_operand_loader_if: operand byte stream in and result stream out of the loader.
interface dot_operand_loader_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;

    modport master (
        output in_data, in_valid, in_last, res_ready,
        input  in_ready, res_data, res_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, res_ready,
        output in_ready, res_data, res_valid
    );

endinterface

// File: rtl/dot_operand_loader.sv
// dot_operand_loader: stages one A/B operand job for the dot engine, starts it,
// watches for completion and hands back the 16-bit result.
module dot_operand_loader
    import npu_pkg::*;
#(
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dot_operand_loader_if.slave       bus,
    output logic [VEC_LEN-1:0][7:0]   o_vec_a,
    output logic [VEC_LEN-1:0][7:0]   o_vec_b,
    output logic                      o_dot_start,
    input  logic                      i_dot_done,
    input  logic [15:0]               i_dot_c,
    output logic                      o_err_len,
    output logic                      o_err_timeout,
    output logic                      o_busy
);

    localparam int IW = $clog2(2*VEC_LEN) + 1;
    localparam int AW = $clog2(VEC_LEN);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(2*VEC_LEN - 1);
    localparam logic [IW-1:0] B_BASE   = IW'(VEC_LEN);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

    ld_state_t                r_state;
    ld_state_t                w_state_nxt;
    logic [IW-1:0]            r_idx;
    logic [WW-1:0]            r_wd;
    logic                     r_done_q;
    logic [VEC_LEN-1:0][7:0]  r_bank_a;
    logic [VEC_LEN-1:0][7:0]  r_bank_b;
    logic [15:0]              r_res_data;
    logic                     r_res_valid;
    logic                     r_err_len;
    logic                     r_err_timeout;

    logic w_acc;
    logic w_at_end;
    logic w_job_ok;
    logic w_job_bad;
    logic w_edge;
    logic w_expire;
    logic w_res_take;

    always_comb begin
        w_acc       = bus.in_valid && (r_state == LOAD);
        w_at_end    = r_idx == LAST_IDX;
        w_job_ok    = w_acc && w_at_end && bus.in_last;
        w_job_bad   = w_acc && !w_job_ok && (w_at_end || bus.in_last);
        // only a fresh rising edge completes; a level left high from before times out
        w_edge      = (r_state == WAIT) && i_dot_done && !r_done_q;
        w_expire    = (r_state == WAIT) && !w_edge && (r_wd == WD_MAX);
        w_res_take  = (r_state == RESULT) && bus.res_ready;
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    w_state_nxt = w_job_ok ? START : LOAD;
            START:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = w_edge ? RESULT : (w_expire ? LOAD : WAIT);
            RESULT:  w_state_nxt = w_res_take ? LOAD : RESULT;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LOAD;
            r_idx         <= '0;
            r_wd          <= '0;
            r_done_q      <= 1'b0;
            r_bank_a      <= '0;
            r_bank_b      <= '0;
            r_res_data    <= '0;
            r_res_valid   <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_done_q      <= i_dot_done;
            r_err_len     <= w_job_bad;
            r_err_timeout <= w_expire;
            if (w_acc && r_idx < B_BASE)
                r_bank_a[AW'(r_idx)] <= bus.in_data;
            else if (w_acc)
                r_bank_b[AW'(r_idx - B_BASE)] <= bus.in_data;
            if (w_job_ok || w_job_bad || w_expire || w_res_take)
                r_idx <= '0;
            else if (w_acc)
                r_idx <= r_idx + IW'(1);
            if (r_state == START)
                r_wd <= '0;
            else if (r_state == WAIT && !w_edge && !w_expire)
                r_wd <= r_wd + WW'(1);
            if (w_edge) begin
                r_res_data  <= i_dot_c;
                r_res_valid <= 1'b1;
            end else if (w_res_take) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = r_state == LOAD;
    assign bus.res_data   = r_res_data;
    assign bus.res_valid  = r_res_valid;
    assign o_vec_a        = r_bank_a;
    assign o_vec_b        = r_bank_b;
    assign o_dot_start    = r_state == START;
    assign o_busy         = r_state != LOAD;
    assign o_err_len      = r_err_len;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_dot_operand_loader.sv
// tb_dot_operand_loader: random and directed jobs against a byte-level job model
// with a bench-side engine stand-in.
module tb_dot_operand_loader;
    import npu_pkg::*;

    localparam int VL = DEF_VEC_LEN;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_operand_loader_if bus();
    int8_vec_t   vec_a;
    int8_vec_t   vec_b;
    logic        dot_start;
    logic        dot_done;
    logic [15:0] dot_c;
    logic        err_len;
    logic        err_to;
    logic        busy;

    dot_operand_loader #(.VEC_LEN(VL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_vec_a      (vec_a),
        .o_vec_b      (vec_b),
        .o_dot_start  (dot_start),
        .i_dot_done   (dot_done),
        .i_dot_c      (dot_c),
        .o_err_len    (err_len),
        .o_err_timeout(err_to),
        .o_busy       (busy)
    );

    logic [7:0] ma [VL];
    logic [7:0] mb [VL];
    int m_idx;
    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_idx = 0;
        for (int i = 0; i < VL; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
    endtask

    function automatic logic [15:0] dotp();
        int s;
        s = 0;
        for (int i = 0; i < VL; i++)
            s += int'($signed(ma[i])) * int'($signed(mb[i]));
        return s[15:0];
    endfunction

    task automatic chk_banks();
        int8_vec_t ea;
        int8_vec_t eb;
        for (int i = 0; i < VL; i++) begin
            ea[i] = ma[i];
            eb[i] = mb[i];
        end
        chk("vec_a", vec_a, ea);
        chk("vec_b", vec_b, eb);
    endtask

    task automatic put_byte(input logic [7:0] b, input bit last, input int gap, output bit go);
        bit err;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        chk("in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (m_idx < VL) ma[m_idx] = b;
        else mb[m_idx - VL] = b;
        go  = (m_idx == 2*VL - 1) && last;
        err = !go && (last || m_idx == 2*VL - 1);
        m_idx = (go || err) ? 0 : m_idx + 1;
        chk("err_len", err_len, err);
        chk("dot_start", dot_start, go);
    endtask

    task automatic job(input int n, input int last_at, input bit pat, input bit gaps, output bit go);
        logic [7:0] b;
        bit g;
        go = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = pat ? ((i < VL) ? 8'(i + 1) : 8'd2) : 8'($urandom);
            put_byte(b, i == last_at, gaps ? int'($urandom_range(0, 2)) : 0, g);
            go = g;
        end
    endtask

    task automatic finish(input logic [15:0] exp, input int dly, input int rdly, input bit keep);
        dot_done = 1'b0;
        for (int k = 0; k < dly; k++) begin
            tick();
            if (k == 0) chk("start_one_cycle", dot_start, 0);
            chk("res_valid_early", bus.res_valid, 0);
        end
        dot_c    = exp;
        dot_done = 1'b1;
        tick();
        chk("res_valid", bus.res_valid, 1);
        chk("res_data", bus.res_data, exp);
        chk("busy_result", busy, 1);
        chk("in_ready_result", bus.in_ready, 0);
        dot_c = 16'($urandom);
        for (int k = 0; k < rdly; k++) begin
            tick();
            chk("res_hold_valid", bus.res_valid, 1);
            chk("res_hold_data", bus.res_data, exp);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("res_valid_clr", bus.res_valid, 0);
        chk("in_ready_after", bus.in_ready, 1);
        chk("busy_after", busy, 0);
        if (!keep) dot_done = 1'b0;
    endtask

    task automatic expire();
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk("timeout_early", err_to, 0);
        end
        tick();
        chk("err_timeout", err_to, 1);
        chk("timeout_no_res", bus.res_valid, 0);
        chk("timeout_in_ready", bus.in_ready, 1);
        chk("timeout_err_len", err_len, 0);
        tick();
        chk("timeout_pulse", err_to, 0);
    endtask

    task automatic good_job(input bit gaps);
        bit go;
        job(2*VL, 2*VL - 1, 1'b0, gaps, go);
        chk("go", go, 1);
        chk_banks();
        finish(dotp(), int'($urandom_range(1, TO - 2)), int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        bit go;
        n_cmp = 0;
        n_bad = 0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
        dot_done      = 1'b0;
        dot_c         = 16'h0000;
        model_clear();
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_vec_a", vec_a, 0);
        chk("rst_vec_b", vec_b, 0);
        chk("rst_start", dot_start, 0);
        chk("rst_res", {bus.res_valid, bus.res_data}, 0);
        chk("rst_errs", {err_len, err_to, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // pattern job with a fixed engine answer
        job(2*VL, 2*VL - 1, 1'b1, 1'b0, go);
        chk("pat_go", go, 1);
        chk_banks();
        finish(16'h0040, 3, 4, 1'b0);

        // early in_last, then a clean job
        job(10, 9, 1'b1, 1'b1, go);
        chk("short_go", go, 0);
        good_job(1'b1);

        // no in_last on the 64th byte, then boundary: in_last one byte early
        job(2*VL, -1, 1'b0, 1'b0, go);
        chk("nolast_go", go, 0);
        job(2*VL - 1, 2*VL - 2, 1'b0, 1'b0, go);
        chk("early_go", go, 0);
        good_job(1'b0);

        // engine never answers
        job(2*VL, 2*VL - 1, 1'b0, 1'b0, go);
        expire();
        good_job(1'b0);

        // dot_done left high: next job times out, a fresh edge completes the one after
        job(2*VL, 2*VL - 1, 1'b0, 1'b0, go);
        finish(dotp(), 2, 0, 1'b1);
        job(2*VL, 2*VL - 1, 1'b0, 1'b0, go);
        expire();
        job(2*VL, 2*VL - 1, 1'b0, 1'b0, go);
        chk("stuck_busy", busy, 1);
        finish(dotp(), 2, 1, 1'b0);

        // reset while waiting on the engine
        job(2*VL, 2*VL - 1, 1'b0, 1'b0, go);
        tick();
        chk("wait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_vec_a", vec_a, 0);
        chk("arst_vec_b", vec_b, 0);
        chk("arst_outs", {dot_start, bus.res_valid, bus.res_data, err_len, err_to, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1);
        good_job(1'b1);

        // random mix of malformed and good jobs
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                int la;
                la = int'($urandom_range(0, 2*VL - 2));
                job(la + 1, la, 1'b0, 1'b1, go);
                chk("rand_bad_go", go, 0);
            end else begin
                good_job($urandom_range(0, 1) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_operand_loader.md
# dot_operand_loader

Upstream feeder for the 32-lane int8 dot-product engine. Accepts a byte stream carrying one job (32 A bytes, then 32 B bytes), stages it in two register banks driven onto the engine's operand vectors, pulses the engine start, waits for completion with a watchdog, and returns the 16-bit result on a valid/ready port. One job is in flight at a time.

## Interface
Parameters:
- VEC_LEN, 32, elements per operand vector; a job is 2*VEC_LEN bytes.
- TIMEOUT, 256, max cycles in WAIT before the job is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  8  operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- in_last  in  1  marks the final byte of a job
- vec_a  out  8 x VEC_LEN  bank A, to the engine's a[] input
- vec_b  out  8 x VEC_LEN  bank B, to the engine's b[] input
- dot_start  out  1  one-cycle start pulse to the engine
- dot_done  in  1  engine done, treated as a level and edge-detected
- dot_c  in  16  engine result
- res_data  out  16  captured result
- res_valid  out  1  result available
- res_ready  in  1  downstream takes the result
- err_len  out  1  one-cycle pulse: malformed job length
- err_timeout  out  1  one-cycle pulse: engine did not finish
- busy  out  1  high in START, WAIT and RESULT

## Operation
- States: LOAD, START, WAIT, RESULT. Reset state is LOAD.
- LOAD:
  - in_ready=1. A byte is accepted when in_valid && in_ready.
  - Byte index idx (7 bits, 0..2*VEC_LEN-1): idx<VEC_LEN writes vec_a[idx]; otherwise writes vec_b[idx-VEC_LEN]. Then idx++.
  - Accepted byte with idx==2*VEC_LEN-1 and in_last=1: go to START.
  - Accepted byte with in_last=1 and idx<2*VEC_LEN-1, or idx==2*VEC_LEN-1 with in_last=0: err_len pulses, idx returns to 0, state stays LOAD. Bank contents are undefined for the aborted job and are not cleared.
- START: dot_start=1 for exactly one cycle, then WAIT. The watchdog clears.
- WAIT:
  - in_ready=0. Banks are held stable.
  - done_q is dot_done registered. A rising edge is dot_done && !done_q. On a rising edge, dot_c is captured into res_data, res_valid is set, and the state moves to RESULT.
  - The watchdog increments each WAIT cycle. When it reaches TIMEOUT-1 with no edge, err_timeout pulses, no result is produced, idx clears, and the state goes to LOAD.
- RESULT:
  - res_data and res_valid are held until res_ready=1.
  - On res_valid && res_ready: res_valid clears, idx clears, and the state goes to LOAD in the same cycle.
- Edge detection: a dot_done already high when START is entered does not complete the job. Only a fresh rising edge does; otherwise the job times out.
- Arithmetic: res_data = dot_c unmodified (16 bits, no saturation). The watchdog is $clog2(TIMEOUT)+1 bits wide and wraps only through the clear in START.

## Timing
- Reset values:
  - Outputs: in_ready=1, vec_a=0, vec_b=0, dot_start=0, res_data=0, res_valid=0, err_len=0, err_timeout=0, busy=0.
  - Internal: idx=0, done_q=0, state=LOAD.
- Reset mid-job aborts immediately. There is no replay, and the engine's own state is the engine's concern.
- Full-rate load takes 2*VEC_LEN cycles. dot_start is high the cycle after the last byte is accepted.
- The result appears one cycle after the cycle in which the rising edge of dot_done is sampled.
- If res_ready is held high, the next job's first byte is accepted the cycle after the result handshake.
- in_ready is combinational from state only. It does not depend on in_valid.
- err_len and err_timeout are registered one-cycle pulses. They never both fire in the same cycle.

## Structure
- Shared package npu_pkg holds:
  - VEC_LEN default (32)
  - the loader state enum (LOAD, START, WAIT, RESULT)
  - typedef for an int8 vector of VEC_LEN elements
- No sub-module. A single always_ff for the state, index, banks and watchdog, plus combinational output decode.

## Test plan
- Bytes 1..32 then 2 x32, in_last on byte 64, engine model returns 0x0040 -> vec_a[i]=i+1, vec_b[i]=2, one dot_start pulse, res_data=0x0040, res_valid held until res_ready.
- in_last on byte 10 -> err_len pulse, no dot_start. A following correct 64-byte job completes normally.
- 64 bytes with no in_last -> err_len on byte 64, no dot_start, idx back to 0.
- Engine model never raises dot_done, TIMEOUT=16 -> err_timeout exactly 16 cycles after entering WAIT, no res_valid, in_ready=1 next cycle.
- dot_done stuck high from the previous job -> second job times out. Toggling dot_done low then high completes it.
- rst_n asserted in WAIT with res_ready=0 -> all outputs return to reset values asynchronously, and in_ready=1 after release.
